// File: rtl/adc_uart_sched.sv
// adc_uart_sched: round-robin scheduler that frames ADC samples and status
// bytes and hands them byte by byte to a UART transmitter.
// An ADC frame is header, sample high bits, sample low bits. A message frame
// is header, status byte. Each byte is loaded, started, then tracked through
// the transmitter's busy high and busy low phases. An optional idle gap
// follows each byte. If tx_busy never rises, a watchdog sets the sticky
// tx_err flag and abandons the frame.
// Optional feature: define ADC_UART_SCHED_CHECKSUM_EN to append one XOR
// checksum byte to every frame.
module adc_uart_sched #(
    parameter int          ADC_W   = 12,
    parameter logic [7:0]  ADC_HDR = 8'hA5,
    parameter logic [7:0]  MSG_HDR = 8'h5A,
    parameter int          GAP     = 2,
    parameter int          TIMEOUT = 16
) (
    input  logic             uart_clk_tx,
    input  logic             RST_n,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic             adc_ready,
    input  logic [7:0]       msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [7:0]       tx_byte,
    output logic             tx_start,
    input  logic             tx_busy,
    output logic             frame_busy,
    output logic             tx_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        GAP_W   = 3'd5
    } state_t;

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
`ifdef ADC_UART_SCHED_CHECKSUM_EN
    localparam logic [2:0] CS_LEN = 3'd1;
`else
    localparam logic [2:0] CS_LEN = 3'd0;
`endif

    state_t           state_r, state_nx;
    logic [7:0]       cnt_r, cnt_nx;
    logic [2:0]       idx_r, idx_nx;
    logic             is_adc_r, is_adc_nx;
    logic [ADC_W-1:0] adc_q_r, adc_q_nx;
    logic [7:0]       msg_q_r, msg_q_nx;
    logic             last_adc_r, last_adc_nx;
    logic [7:0]       tx_byte_r, tx_byte_nx;
    logic             tx_start_r, tx_start_nx;
    logic             adc_ready_r, adc_ready_nx;
    logic             msg_ready_r, msg_ready_nx;
    logic             frame_busy_r, frame_busy_nx;
    logic             tx_err_r, tx_err_nx;
`ifdef ADC_UART_SCHED_CHECKSUM_EN
    logic [7:0]       csum_r, csum_nx;
`endif
    logic             grant_adc_s, grant_msg_s;
    logic [2:0]       frame_len_s;
    logic             last_byte_s;

    // Payload byte at a given position of the current frame (checksum excluded).
    function automatic logic [7:0] frame_byte(input logic is_adc, input logic [2:0] idx,
                                              input logic [ADC_W-1:0] adc, input logic [7:0] msg);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = is_adc ? ADC_HDR : MSG_HDR;
            3'd1:    b = is_adc ? 8'(adc >> 8) : msg;
            3'd2:    b = adc[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ADC wins unless msg also requests and ADC was served last.
    assign grant_adc_s = adc_valid && (!msg_valid || !last_adc_r);
    assign grant_msg_s = msg_valid && !grant_adc_s;
    assign frame_len_s = (is_adc_r ? 3'd3 : 3'd2) + CS_LEN;
    assign last_byte_s = (idx_r == frame_len_s);

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        idx_nx       = idx_r;
        is_adc_nx    = is_adc_r;
        adc_q_nx     = adc_q_r;
        msg_q_nx     = msg_q_r;
        last_adc_nx  = last_adc_r;
        tx_byte_nx   = tx_byte_r;
        adc_ready_nx = 1'b0;
        msg_ready_nx = 1'b0;
        tx_err_nx    = tx_err_r;
`ifdef ADC_UART_SCHED_CHECKSUM_EN
        csum_nx      = csum_r;
`endif
        case (state_r)
            IDLE: begin
                cnt_nx = 8'd0;
                idx_nx = 3'd0;
`ifdef ADC_UART_SCHED_CHECKSUM_EN
                csum_nx = 8'h00;
`endif
                if (grant_adc_s) begin
                    adc_ready_nx = 1'b1;
                    is_adc_nx    = 1'b1;
                    adc_q_nx     = adc_data;
                    last_adc_nx  = 1'b1;
                    state_nx     = LOAD;
                end else if (grant_msg_s) begin
                    msg_ready_nx = 1'b1;
                    is_adc_nx    = 1'b0;
                    msg_q_nx     = msg_data;
                    last_adc_nx  = 1'b0;
                    state_nx     = LOAD;
                end else begin
                    state_nx = IDLE;
                end
            end
            LOAD: begin
`ifdef ADC_UART_SCHED_CHECKSUM_EN
                if (idx_r == frame_len_s - 3'd1) begin
                    tx_byte_nx = csum_r;
                end else begin
                    tx_byte_nx = frame_byte(is_adc_r, idx_r, adc_q_r, msg_q_r);
                    csum_nx    = csum_r ^ frame_byte(is_adc_r, idx_r, adc_q_r, msg_q_r);
                end
`else
                tx_byte_nx = frame_byte(is_adc_r, idx_r, adc_q_r, msg_q_r);
`endif
                idx_nx   = idx_r + 3'd1;
                state_nx = START;
            end
            START: begin
                // One cycle has already elapsed since tx_start rose when WAIT_HI begins.
                cnt_nx   = 8'd1;
                state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    cnt_nx   = 8'd0;
                    state_nx = WAIT_LO;
                end else if (cnt_r >= TO_LAST) begin
                    cnt_nx    = 8'd0;
                    tx_err_nx = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt_r + 8'd1;
                end
            end
            WAIT_LO: begin
                cnt_nx = 8'd0;
                if (tx_busy) begin
                    state_nx = WAIT_LO;
                end else if (GAP != 0) begin
                    state_nx = GAP_W;
                end else if (last_byte_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = LOAD;
                end
            end
            GAP_W: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nx   = 8'd0;
                    state_nx = last_byte_s ? IDLE : LOAD;
                end else begin
                    cnt_nx = cnt_r + 8'd1;
                end
            end
            default: begin
                cnt_nx   = 8'd0;
                state_nx = IDLE;
            end
        endcase
        tx_start_nx   = (state_nx == START);
        frame_busy_nx = (state_nx != IDLE);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge uart_clk_tx) begin
        if (!RST_n) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            idx_r        <= 3'd0;
            is_adc_r     <= 1'b0;
            adc_q_r      <= '0;
            msg_q_r      <= 8'h00;
            last_adc_r   <= 1'b0;
            tx_byte_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            adc_ready_r  <= 1'b0;
            msg_ready_r  <= 1'b0;
            frame_busy_r <= 1'b0;
            tx_err_r     <= 1'b0;
`ifdef ADC_UART_SCHED_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            state_r      <= state_nx;
            cnt_r        <= cnt_nx;
            idx_r        <= idx_nx;
            is_adc_r     <= is_adc_nx;
            adc_q_r      <= adc_q_nx;
            msg_q_r      <= msg_q_nx;
            last_adc_r   <= last_adc_nx;
            tx_byte_r    <= tx_byte_nx;
            tx_start_r   <= tx_start_nx;
            adc_ready_r  <= adc_ready_nx;
            msg_ready_r  <= msg_ready_nx;
            frame_busy_r <= frame_busy_nx;
            tx_err_r     <= tx_err_nx;
`ifdef ADC_UART_SCHED_CHECKSUM_EN
            csum_r       <= csum_nx;
`endif
        end
    end

    assign tx_byte    = tx_byte_r;
    assign tx_start   = tx_start_r;
    assign adc_ready  = adc_ready_r;
    assign msg_ready  = msg_ready_r;
    assign frame_busy = frame_busy_r;
    assign tx_err     = tx_err_r;

endmodule

// File: tb/tb_adc_uart_sched.sv
// Self-checking bench for adc_uart_sched: a byte-level frame model feeds an
// expected-byte queue that is compared on every tx_start; directed scenarios
// cover reset, framing, round-robin, watchdog timeout and mid-frame reset.
module tb_adc_uart_sched;
    localparam int ADC_W    = 12;
    localparam int GAP      = 2;
    localparam int TIMEOUT  = 16;
    localparam int BUSY_CYC = 10;
`ifdef ADC_UART_SCHED_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic             uart_clk_tx = 1'b0;
    logic             RST_n;
    logic [ADC_W-1:0] adc_data;
    logic             adc_valid;
    logic             adc_ready;
    logic [7:0]       msg_data;
    logic             msg_valid;
    logic             msg_ready;
    logic [7:0]       tx_byte;
    logic             tx_start;
    logic             tx_busy;
    logic             frame_busy;
    logic             tx_err;

    adc_uart_sched #(.ADC_W(ADC_W), .ADC_HDR(8'hA5), .MSG_HDR(8'h5A), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .uart_clk_tx(uart_clk_tx), .RST_n(RST_n),
        .adc_data(adc_data), .adc_valid(adc_valid), .adc_ready(adc_ready),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .frame_busy(frame_busy), .tx_err(tx_err)
    );

    always #5 uart_clk_tx = ~uart_clk_tx;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int         adc_pulses = 0, msg_pulses = 0;
    int         cyc = 0, start_cyc = 0, err_rise_cyc = 0, busy_fall_cyc = 0, fb_fall_cyc = 0;
    bit         tx_en = 1'b1;
    bit         model_last_adc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: build a frame from its payload bytes, appending the XOR when enabled.
    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [7:0] f[3];
        logic [7:0] x;
        f = '{b0, b1, b2};
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(f[i]);
            x = x ^ f[i];
        end
        if (CS == 1) exp_q.push_back(x);
    endtask

    task automatic model_adc(input logic [ADC_W-1:0] d);
        push_frame(8'hA5, 8'(d >> 8), d[7:0], 3);
    endtask

    task automatic model_msg(input logic [7:0] m);
        push_frame(8'h5A, m, 8'h00, 2);
    endtask

    task automatic step();
        @(negedge uart_clk_tx);
        #1;
    endtask

    task automatic wait_ready(output bit got_adc);
        int n;
        n = 0;
        got_adc = 1'b0;
        while (n < 400 && !(adc_ready === 1'b1 || msg_ready === 1'b1)) begin
            step();
            n++;
        end
        if (n >= 400) begin
            failures++; checks++;
            $display("FAIL ready_timeout actual=none required=pulse");
        end else begin
            got_adc = (adc_ready === 1'b1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 400 && frame_busy !== 1'b0) begin
            step();
            n++;
        end
        if (n >= 400) begin
            failures++; checks++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        repeat (2) @(posedge uart_clk_tx);
        #1;
        RST_n = 1'b1;
        model_last_adc = 1'b0;
    endtask

    // Transmitter model: busy for BUSY_CYC cycles after each accepted tx_start.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge uart_clk_tx);
            #1;
            if (tx_en && tx_start === 1'b1) begin
                tx_busy = 1'b1;
                repeat (BUSY_CYC) @(posedge uart_clk_tx);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // Compare process: each tx_start must carry the next modelled byte.
    initial begin
        logic prev_start, prev_busy, prev_err, prev_fb;
        prev_start = 1'b0; prev_busy = 1'b0; prev_err = 1'b0; prev_fb = 1'b0;
        forever begin
            @(negedge uart_clk_tx);
            cyc++;
            if (RST_n === 1'b1) begin
                if (tx_start === 1'b1) begin
                    check("tx_start_one_cycle", 32'(prev_start), 32'd0);
                    check("frame_busy_on_start", 32'(frame_busy), 32'd1);
                    if (exp_q.size() == 0) begin
                        failures++; checks++;
                        $display("FAIL unexpected_byte actual=%0h required=none", tx_byte);
                    end else begin
                        check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
                    end
                    log_q.push_back(tx_byte);
                    start_cyc = cyc;
                end
                if (adc_ready === 1'b1) adc_pulses++;
                if (msg_ready === 1'b1) msg_pulses++;
                if (adc_ready === 1'b1 || msg_ready === 1'b1)
                    check("single_ready", 32'(adc_ready & msg_ready), 32'd0);
                if (tx_err === 1'b1 && !prev_err) err_rise_cyc = cyc;
                if (tx_busy === 1'b0 && prev_busy) busy_fall_cyc = cyc;
                if (frame_busy === 1'b0 && prev_fb) fb_fall_cyc = cyc;
            end
            prev_start = (tx_start === 1'b1);
            prev_busy  = (tx_busy === 1'b1);
            prev_err   = (tx_err === 1'b1);
            prev_fb    = (frame_busy === 1'b1);
        end
    end

    initial begin
        bit got_adc;
        bit exp_adc;
        int base;
        int n;
        RST_n = 1'b0; adc_valid = 1'b0; msg_valid = 1'b0;
        adc_data = '0; msg_data = 8'h00;
        repeat (3) @(posedge uart_clk_tx);
        #1;
        // Reset values
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_adc_ready", 32'(adc_ready), 32'd0);
        check("rst_msg_ready", 32'(msg_ready), 32'd0);
        check("rst_frame_busy", 32'(frame_busy), 32'd0);
        check("rst_tx_err", 32'(tx_err), 32'd0);
        RST_n = 1'b1;
        step();

        // Single ADC frame 12'hABC
        adc_pulses = 0; msg_pulses = 0;
        model_adc(12'hABC);
        adc_data = 12'hABC; adc_valid = 1'b1;
        wait_ready(got_adc);
        adc_valid = 1'b0;
        check("adc_grant", 32'(got_adc), 32'd1);
        wait_idle();
        check("adc_len", 32'(log_q.size()), 32'(3 + CS));
        check("adc_b0", 32'(log_q[0]), 32'hA5);
        check("adc_b1", 32'(log_q[1]), 32'h0A);
        check("adc_b2", 32'(log_q[2]), 32'hBC);
        if (CS == 1) check("adc_csum", 32'(log_q[3]), 32'h13);
        check("adc_pulses", 32'(adc_pulses), 32'd1);
        check("msg_pulses", 32'(msg_pulses), 32'd0);
        check("gap_to_idle", 32'(fb_fall_cyc - busy_fall_cyc), 32'(GAP + 1));

        // Round-robin with both requests held
        do_reset();
        log_q.delete();
        adc_data = 12'hABC; msg_data = 8'h33;
        adc_valid = 1'b1; msg_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_adc = !model_last_adc;
            if (exp_adc) model_adc(12'hABC); else model_msg(8'h33);
            wait_ready(got_adc);
            check("rr_grant", 32'(got_adc), 32'(exp_adc));
            model_last_adc = exp_adc;
            if (k == 2) begin
                adc_valid = 1'b0; msg_valid = 1'b0;
            end
            step();
        end
        wait_idle();
        check("rr_first_hdr", 32'(log_q[0]), 32'hA5);
        check("rr_second_hdr", 32'(log_q[3 + CS]), 32'h5A);
        check("rr_msg_byte", 32'(log_q[4 + CS]), 32'h33);
        if (CS == 1) check("msg_csum", 32'(log_q[5 + CS]), 32'h69);
        check("rr_third_hdr", 32'(log_q[5 + 2 * CS]), 32'hA5);

        // Watchdog: transmitter never goes busy
        tx_en = 1'b0;
        exp_q.push_back(8'hA5);
        adc_valid = 1'b1;
        wait_ready(got_adc);
        adc_valid = 1'b0;
        n = 0;
        while (n < 100 && tx_err !== 1'b1) begin
            step();
            n++;
        end
        check("tx_err_set", 32'(tx_err), 32'd1);
        check("timeout_cycles", 32'(err_rise_cyc - start_cyc), 32'(TIMEOUT));
        check("timeout_idle", 32'(frame_busy), 32'd0);
        tx_en = 1'b1;
        base = log_q.size();
        model_msg(8'h44);
        msg_data = 8'h44; msg_valid = 1'b1;
        wait_ready(got_adc);
        msg_valid = 1'b0;
        check("after_err_grant", 32'(got_adc), 32'd0);
        wait_idle();
        check("after_err_len", 32'(log_q.size() - base), 32'(2 + CS));
        check("tx_err_sticky", 32'(tx_err), 32'd1);

        // Reset during WAIT_LO of the second byte
        base = log_q.size();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h0A);
        adc_valid = 1'b1;
        wait_ready(got_adc);
        adc_valid = 1'b0;
        n = 0;
        while (n < 200 && !(log_q.size() >= base + 2 && tx_busy === 1'b1)) begin
            step();
            n++;
        end
        check("second_byte_busy", 32'(tx_busy), 32'd1);
        repeat (3) step();
        RST_n = 1'b0;
        @(posedge uart_clk_tx);
        #1;
        check("mid_rst_tx_byte", 32'(tx_byte), 32'h00);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_frame_busy", 32'(frame_busy), 32'd0);
        check("mid_rst_tx_err", 32'(tx_err), 32'd0);
        check("mid_rst_ready", 32'({adc_ready, msg_ready}), 32'd0);
        RST_n = 1'b1;
        model_last_adc = 1'b0;
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        n = 0;
        while (n < 50 && tx_busy !== 1'b0) begin
            step();
            n++;
        end
        base = log_q.size();
        model_adc(12'hABC);
        adc_valid = 1'b1;
        wait_ready(got_adc);
        adc_valid = 1'b0;
        wait_idle();
        check("post_rst_hdr", 32'(log_q[base]), 32'hA5);
        check("post_rst_b1", 32'(log_q[base + 1]), 32'h0A);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_uart_sched.md
ADC_UART_SCHED -- requirements
Module: adc_uart_sched

Interface
- REQ-001 SHALL have parameter ADC_W, default 12: ADC sample width; legal range 9..16.
- REQ-002 SHALL have parameter ADC_HDR, default 8'hA5: header byte of an ADC frame.
- REQ-003 SHALL have parameter MSG_HDR, default 8'h5A: header byte of a message frame.
- REQ-004 SHALL have parameter GAP, default 2: idle cycles between bytes; legal range 0..255.
- REQ-005 SHALL have parameter TIMEOUT, default 16: cycles allowed for tx_busy to rise after tx_start; legal range 1..255.
- REQ-006 SHALL have port uart_clk_tx, in, 1: clock; all logic on its rising edge.
- REQ-007 SHALL have port RST_n, in, 1: reset, synchronous, active-low.
- REQ-008 SHALL have ports adc_data (in, ADC_W), adc_valid (in, 1) and adc_ready (out, 1): ADC sample request and one-cycle accept pulse.
- REQ-009 SHALL have ports msg_data (in, 8), msg_valid (in, 1) and msg_ready (out, 1): status byte request and one-cycle accept pulse.
- REQ-010 SHALL have ports tx_byte (out, 8), tx_start (out, 1) and tx_busy (in, 1): byte handoff to the UART transmitter; tx_busy is high while a byte shifts out.
- REQ-011 SHALL have ports frame_busy (out, 1), high while a frame is in progress, and tx_err (out, 1), a sticky timeout flag.

Function
- REQ-012 SHALL implement the FSM states IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP_W.
- REQ-013 IDLE: with at least one valid request, SHALL grant one requester, pulse its ready for one cycle, capture its data, and go to LOAD.
- REQ-014 Arbitration SHALL be round-robin when adc_valid and msg_valid are both high, granting the requester not served last; a single valid requester SHALL be granted directly.
- REQ-015 ADC frame SHALL be three bytes, in order: ADC_HDR, zero-extended adc_data[ADC_W-1:8], adc_data[7:0].
- REQ-016 Message frame SHALL be two bytes, in order: MSG_HDR, msg_data.
- REQ-017 LOAD SHALL drive tx_byte with the current frame byte and go to START; tx_byte SHALL hold stable until WAIT_LO exits.
- REQ-018 START SHALL assert tx_start for exactly one cycle, then go to WAIT_HI.
- REQ-019 WAIT_HI SHALL wait for tx_busy=1, then go to WAIT_LO.
- REQ-020 WAIT_HI SHALL count cycles; if the count reaches TIMEOUT without tx_busy high, it SHALL set tx_err, abandon the frame and return to IDLE.
- REQ-021 WAIT_LO SHALL wait for tx_busy=0, then go to GAP_W.
- REQ-022 GAP_W SHALL idle GAP cycles (GAP=0: zero cycles), then go to LOAD for the next byte, or to IDLE after the last byte.
- REQ-023 frame_busy SHALL be high in every state except IDLE.
- REQ-024 Requests arriving mid-frame SHALL wait; no ready pulse SHALL occur before the frame completes.
- REQ-025 tx_err SHALL clear only on reset.
- REQ-026 If tx_busy is already high on entry to WAIT_HI, the FSM SHALL advance on the next edge.

Reset
- REQ-027 With RST_n low at a clock edge, the block SHALL enter IDLE, abandoning any frame in progress.
- REQ-028 Reset values SHALL be: tx_byte=8'h00, tx_start=0, adc_ready=0, msg_ready=0, frame_busy=0, tx_err=0, counters 0.
- REQ-029 After reset, the round-robin pointer SHALL favour ADC on the first contention.

Configuration
- REQ-030 With macro ADC_UART_SCHED_CHECKSUM_EN defined, every frame SHALL append one final byte equal to the XOR of all preceding bytes of that frame, header included.
- REQ-031 Without ADC_UART_SCHED_CHECKSUM_EN, frames SHALL carry no checksum byte and no checksum logic SHALL be built.

Verification
- REQ-032 ADC_W=12, adc_data=12'hABC, transmitter model busy for 10 cycles per byte -> tx bytes A5,0A,BC, one adc_ready pulse, frame_busy low after the last byte's GAP.
- REQ-033 adc_valid and msg_valid (msg_data=8'h33) high together, both held -> frames sent alternately ADC, MSG, ADC; the first is ADC.
- REQ-034 tx_busy tied 0 -> tx_err=1 exactly TIMEOUT cycles after tx_start; FSM returns to IDLE; the next request is served normally with tx_err still 1.
- REQ-035 RST_n low during WAIT_LO of the second byte -> next edge: all outputs at reset values; the next frame starts with its header byte.
- REQ-036 With ADC_UART_SCHED_CHECKSUM_EN, adc_data=12'hABC -> bytes A5,0A,BC,13; msg_data=8'h33 -> bytes 5A,33,69.
